// File: rtl/led_seq_gen_if.sv
// Control and LED-drive bundle between a pattern controller and led_seq_gen.
// LED_NUM must match the LED_NUM of the led_seq_gen instance it connects to.
interface led_seq_gen_if #(
  parameter int LED_NUM = 4
);
  logic               valid;
  logic [1:0]         mode;
  logic [1:0]         speed;
  logic [LED_NUM-1:0] led;
  logic               step;

  modport master (output valid, mode, speed, input led, step);
  modport slave  (input valid, mode, speed, output led, step);
endinterface

// File: rtl/led_seq_gen.sv
// LED pattern sequencer: run down / run up / ping-pong / blink-all at a
// programmable step period, with a one-cycle step strobe.
//
// state    | meaning
// ST_IDLE  | valid low or just out of reset; LEDs off, next valid edge loads the start pattern
// ST_RUN   | pattern running; counter times the hold, mode change restarts the pattern
module led_seq_gen #(
  parameter int LED_NUM     = 4,
  parameter int STEP_CYCLES = 10_000_000,
  parameter int CNT_W       = 24
) (
  input  logic            sys_clk,
  input  logic            rst_n,
  led_seq_gen_if.slave    bus
);

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  localparam logic [1:0] MODE_DOWN  = 2'b00;
  localparam logic [1:0] MODE_UP    = 2'b01;
  localparam logic [1:0] MODE_PING  = 2'b10;
  localparam logic [1:0] MODE_BLINK = 2'b11;

  state_t             r_state;
  logic [LED_NUM-1:0] r_led;
  logic               r_step;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_dir;     // ping-pong direction: 0 = toward LSB, 1 = toward MSB
  logic [1:0]         r_mode_q;

  logic [CNT_W-1:0]   w_period;
  logic [CNT_W-1:0]   w_period_m1;
  logic [LED_NUM-1:0] w_init;
  logic [LED_NUM-1:0] w_next;
  logic               w_dir_next;

  assign w_period    = CNT_W'(STEP_CYCLES) >> bus.speed;
  assign w_period_m1 = w_period - CNT_W'(1);

  always_comb begin
    w_init = '0;
    case (bus.mode)
      MODE_UP:    w_init[0] = 1'b1;
      MODE_BLINK: w_init = '1;
      default:    w_init[LED_NUM-1] = 1'b1;
    endcase
  end

  // Rotations are written as shift-or so a single LED simply holds.
  always_comb begin
    w_next     = r_led;
    w_dir_next = r_dir;
    case (r_mode_q)
      MODE_DOWN:  w_next = (r_led >> 1) | (r_led << (LED_NUM - 1));
      MODE_UP:    w_next = (r_led << 1) | (r_led >> (LED_NUM - 1));
      MODE_PING: begin
        if (LED_NUM > 1) begin
          if (!r_dir) begin
            w_next     = r_led >> 1;
            w_dir_next = w_next[0];
          end else begin
            w_next     = r_led << 1;
            w_dir_next = ~w_next[LED_NUM-1];
          end
        end
      end
      default:    w_next = ~r_led;
    endcase
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_led    <= '0;
      r_step   <= 1'b0;
      r_cnt    <= '0;
      r_dir    <= 1'b0;
      r_mode_q <= MODE_DOWN;
    end else if (!bus.valid) begin
      r_state  <= ST_IDLE;
      r_led    <= '0;
      r_step   <= 1'b0;
      r_cnt    <= '0;
      r_dir    <= 1'b0;
      r_mode_q <= bus.mode;
    end else if (r_state == ST_IDLE || bus.mode != r_mode_q) begin
      r_state  <= ST_RUN;
      r_led    <= w_init;
      r_step   <= 1'b0;
      r_cnt    <= '0;
      r_dir    <= 1'b0;
      r_mode_q <= bus.mode;
    end else if (r_cnt >= w_period_m1) begin
      // >= so a speed-up takes effect on the very next edge
      r_cnt  <= '0;
      r_led  <= w_next;
      r_dir  <= w_dir_next;
      r_step <= 1'b1;
    end else begin
      r_cnt  <= r_cnt + CNT_W'(1);
      r_step <= 1'b0;
    end
  end

  assign bus.led  = r_led;
  assign bus.step = r_step;

endmodule
